// File: rtl/pdp8_io_hub_pkg.sv
// Shared definitions for the PDP-8 I/O hub: word widths, DMA direction and
// the data-break arbiter state encoding.
package pdp8_io_pkg;

    localparam int PDP8_DW = 12;
    localparam int PDP8_AW = 15;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dma_dir_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Slot index reached by stepping k places past v with wrap at n slots.
    function automatic int unsigned wrap_inc(input int unsigned v,
                                             input int unsigned k,
                                             input int unsigned n);
        return (v + k) % n;
    endfunction

endpackage

// File: rtl/pdp8_io_hub_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', scanning
// with wrap at NCHAN (which need not be a power of two).
module pdp8_rr_arbiter
    import pdp8_io_pkg::*;
#(
    parameter int NCHAN = 4,
    localparam int IW   = $clog2(NCHAN)
) (
    input  logic [NCHAN-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    grant,
    output logic             valid
);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int k = 1; k <= NCHAN; k++) begin
            idx = wrap_inc(32'(last), k, NCHAN);
            if (!valid && req[idx[IW-1:0]]) begin
                grant = idx[IW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdp8_io_hub.sv
// I/O hub between the PDP-8 CPU and NCHAN device slots: IOT response mux,
// masked interrupt combine, and a round-robin data-break (DMA) arbiter.
module pdp8_io_hub
    import pdp8_io_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int DW    = PDP8_DW,
    parameter int AW    = PDP8_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCHAN-1:0]    int_enable,
    input  logic [NCHAN-1:0]    dev_selected,
    input  logic [NCHAN*DW-1:0] dev_data_out,
    input  logic [NCHAN-1:0]    dev_data_avail,
    input  logic [NCHAN-1:0]    dev_skip,
    input  logic [NCHAN-1:0]    dev_clear_ac,
    input  logic [NCHAN-1:0]    dev_interrupt,
    input  logic [NCHAN-1:0]    dev_ram_read_req,
    input  logic [NCHAN-1:0]    dev_ram_write_req,
    input  logic [NCHAN*AW-1:0] dev_ram_ma,
    input  logic [NCHAN*DW-1:0] dev_ram_out,
    output logic [NCHAN-1:0]    dev_ram_done,
    output logic [DW-1:0]       io_data_out,
    output logic                io_data_avail,
    output logic                io_skip,
    output logic                io_clear_ac,
    output logic                io_interrupt,
    output logic                io_select_error,
    output logic                io_ram_read_req,
    output logic                io_ram_write_req,
    output logic [AW-1:0]       io_ram_ma,
    output logic [DW-1:0]       io_ram_out,
    input  logic                io_ram_done
);

    localparam int IW = $clog2(NCHAN);

    // Data-break handshake: a slot holds its read/write request until it
    // sees its one-cycle dev_ram_done; the memory request is held from the
    // cycle after the grant until io_ram_done is seen.
    arb_state_e       state;
    logic [IW-1:0]    grant_q;
    logic [IW-1:0]    rr_last;
    dma_dir_e         dir_q;
    logic [AW-1:0]    ma_q;
    logic [DW-1:0]    wdata_q;

    logic [NCHAN-1:0] req;
    logic [IW-1:0]    pick;
    logic             pick_valid;
    logic             busy;
    logic             sel_found;

    assign req = dev_ram_read_req | dev_ram_write_req;

    pdp8_rr_arbiter #(.NCHAN(NCHAN)) u_arb (
        .req   (req),
        .last  (rr_last),
        .grant (pick),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            grant_q         <= '0;
            rr_last         <= IW'(NCHAN - 1);
            dir_q           <= DIR_READ;
            ma_q            <= '0;
            wdata_q         <= '0;
            io_interrupt    <= 1'b0;
            io_select_error <= 1'b0;
        end else begin
            io_interrupt <= |(dev_interrupt & int_enable);
            if ($countones(dev_selected) > 1) begin
                io_select_error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick;
                        dir_q   <= dev_ram_read_req[pick] ? DIR_READ : DIR_WRITE;
                        ma_q    <= dev_ram_ma[int'(pick)*AW +: AW];
                        wdata_q <= dev_ram_out[int'(pick)*DW +: DW];
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // The granted slot may drop its request; the latched transfer still finishes.
                    if (io_ram_done) begin
                        rr_last <= grant_q;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = (state == BUSY);
    assign io_ram_read_req  = busy && (dir_q == DIR_READ);
    assign io_ram_write_req = busy && (dir_q == DIR_WRITE);
    assign io_ram_ma        = ma_q;
    assign io_ram_out       = wdata_q;

    always_comb begin
        dev_ram_done = '0;
        if (busy && io_ram_done && !reset) begin
            dev_ram_done[grant_q] = 1'b1;
        end
    end

    // Lowest-index selected slot owns the IOT response.
    always_comb begin
        sel_found     = 1'b0;
        io_data_out   = '0;
        io_data_avail = 1'b0;
        io_skip       = 1'b0;
        io_clear_ac   = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (!sel_found && dev_selected[i]) begin
                sel_found     = 1'b1;
                io_data_out   = dev_data_out[i*DW +: DW];
                io_data_avail = dev_data_avail[i];
                io_skip       = dev_skip[i];
                io_clear_ac   = dev_clear_ac[i];
            end
        end
    end

endmodule

// File: doc/pdp8_io_hub.md
Name: pdp8_io_hub

Overview:
Parametrised I/O hub between the PDP-8 CPU and NCHAN peripheral controllers.
- Muxes IOT responses (data, data-avail, skip, clear-AC) from whichever device is selected.
- Combines interrupt requests through a per-channel enable mask.
- Arbitrates data-break (DMA) RAM requests round-robin onto the single CPU memory port, with a latched request/done handshake.
- Replaces the fixed three-device glue; devices attach by slot index.

Parameters:
NCHAN, 4, number of device slots (2..8)
DW, 12, data word width
AW, 15, RAM address width (field + address)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
int_enable  in  NCHAN  per-slot interrupt enable mask
dev_selected  in  NCHAN  device decoded current IOT
dev_data_out  in  NCHAN*DW  device IOT read data; slot i at [i*DW +: DW]
dev_data_avail  in  NCHAN  device drives AC this IOT
dev_skip  in  NCHAN  device skip request
dev_clear_ac  in  NCHAN  device clear-AC request
dev_interrupt  in  NCHAN  device interrupt level
dev_ram_read_req  in  NCHAN  DMA read request, held until done
dev_ram_write_req  in  NCHAN  DMA write request, held until done
dev_ram_ma  in  NCHAN*AW  DMA address per slot
dev_ram_out  in  NCHAN*DW  DMA write data per slot
dev_ram_done  out  NCHAN  one-cycle completion pulse to the granted slot
io_data_out  out  DW  to CPU
io_data_avail  out  1  to CPU
io_skip  out  1  to CPU
io_clear_ac  out  1  to CPU
io_interrupt  out  1  registered interrupt request to CPU
io_select_error  out  1  sticky: more than one slot selected in the same cycle
io_ram_read_req  out  1  to memory
io_ram_write_req  out  1  to memory
io_ram_ma  out  AW  to memory
io_ram_out  out  DW  to memory
io_ram_done  in  1  memory completion

Behaviour:
- Clock and reset: single clock domain, clk. reset is synchronous and active-high. Reset state:
  - All registered outputs 0; io_select_error 0; arbiter IDLE.
  - rr_last = NCHAN-1, so slot 0 has first priority after reset.
- IOT mux (combinational, zero latency):
  - The lowest-index slot with dev_selected=1 drives io_data_out, io_data_avail, io_skip and io_clear_ac.
  - With no slot selected, all four are 0.
- Select conflict: if popcount(dev_selected) > 1 on any clock edge, io_select_error sets. It stays set until reset.
- Interrupt:
  - io_interrupt <= |(dev_interrupt & int_enable), registered, so latency is 1 cycle.
  - It is level-sensitive with no latching; the device holds its level until the CPU services it.
- DMA arbiter FSM, states IDLE and BUSY:
  - IDLE, with req[i] = read_req[i] | write_req[i]:
    - If any req is set, grant the first requesting slot scanning rr_last+1, rr_last+2, ... with modulo-NCHAN wrap.
    - Latch grant, dir (read wins if the slot asserts both), ma and wdata from that slot. Next state BUSY.
    - No request: stay in IDLE.
  - BUSY:
    - io_ram_read_req / io_ram_write_req = latched dir. io_ram_ma and io_ram_out come from the latches. Requests become visible the cycle after the grant.
    - On io_ram_done=1: dev_ram_done[grant] pulses for that same cycle (combinational); other slots stay 0. Next state IDLE and rr_last <= grant.
  - Outside BUSY: io_ram_*_req = 0 and dev_ram_done = 0.
  - A slot dropping its request while granted has no effect; the latched transfer completes.
  - io_ram_done arriving in IDLE is ignored.
  - Minimum spacing between grants is 2 cycles (BUSY -> IDLE -> BUSY). A slot holding its request gets re-granted only after every other requester has had a turn.
- Reset mid-transfer: requests drop the same edge, no done pulse is generated, and rr_last returns to NCHAN-1.
- Widths: grant and rr_last are clog2(NCHAN) bits. Wrap arithmetic is modulo NCHAN, not a power of two.

Decomposition:
- Shared package pdp8_io_pkg holds:
  - PDP8_DW=12 and PDP8_AW=15.
  - The DMA direction encoding (DIR_READ=0, DIR_WRITE=1).
  - The arbiter state typedef {IDLE, BUSY}.
- One sub-module is natural: pdp8_rr_arbiter. It is a combinational round-robin picker with inputs req[NCHAN] and last, and outputs grant and valid; it is reused by later multi-master blocks.
- The FSM, latches, IOT mux and interrupt register stay in pdp8_io_hub.

Test Plan:
1. IOT mux: dev_selected=4'b0100, slot2 data=12'o1234, avail=1, skip=1 -> io_data_out=12'o1234, io_data_avail=1, io_skip=1 in the same cycle; io_select_error stays 0.
2. Conflict: dev_selected=4'b0110 for 1 cycle, slot1 data=12'o0077 -> io_data_out=12'o0077; io_select_error=1 and still 1 after 10 idle cycles; cleared only by reset.
3. Interrupt: dev_interrupt=4'b1000 with int_enable=4'b0111 -> io_interrupt stays 0. Set int_enable[3]=1 -> io_interrupt=1 exactly 1 cycle later.
4. Round-robin: after reset, slots 1 and 3 hold write_req continuously, memory returns done 2 cycles after each req -> grant order 1,3,1,3. Each dev_ram_done pulse is 1 cycle and goes only to the granted slot; io_ram_ma/io_ram_out match that slot's 15'o12345/12'o7070 values.
5. Latching: slot0 read_req at ma=15'o00200, drops req and changes ma to 15'o00300 while BUSY -> io_ram_ma stays 15'o00200 and io_ram_read_req stays 1 until done; dev_ram_done[0] pulses once.
6. Reset mid-op: assert reset while BUSY with slot2 -> io_ram_*_req=0 on that edge, no dev_ram_done pulse. After release, with slots 0 and 2 both requesting, slot0 is granted first.
